// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared types and constants for the CPU memory subsystem.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  // RAM model handshake state as seen by the arbiter
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Returned instead of RAM data when the RAM reports an error
  localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Bundle of the arbiter's requester- and RAM-side signals.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic nRST
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              mem_err;

  // Arbiter's view of the bundle
  modport arb (
    input  CLK, nRST,
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one RAM port between instruction fetch and data access.
//          Data has priority; a starvation counter forces fetches through.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W       = CPU_WORD_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam logic [3:0]        LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [WORD_W-1:0] BAD_LD  = WORD_W'(BAD_WORD);

  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;

  ramstate_t  rs;
  logic       d_req;
  logic       ram_done;
  logic       i_done;
  logic       d_done;

  assign rs       = ramstate_t'(ramstate);
  assign d_req    = dREN | dWEN;
  // ERROR also ends the transaction so the pipeline never hangs
  assign ram_done = (rs == ACCESS) || (rs == ERROR);
  assign mem_err  = err_q;

  // State, starvation counter and sticky error registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Next state: arbitrate in IDLE, on completion, or when the owner drops out
  always_comb begin
    arb_state_t arb;
    starve_d = starve_q;
    if (!iREN || i_done)
      starve_d = '0;
    else if (d_done && (starve_q != LIMIT))
      starve_d = starve_q + 4'd1;

    err_d = err_q;
    if ((state_q != IDLE) && (rs == ERROR))
      err_d = 1'b1;

    // Uses the post-update count so the fetch wins right after the last
    // permitted data grant, with no extra data grant slipping in
    arb = IDLE;
    if (d_req && iREN)
      arb = (starve_d == LIMIT) ? IGRANT : DGRANT;
    else if (d_req)
      arb = DGRANT;
    else if (iREN)
      arb = IGRANT;

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb;
      IGRANT:  if (!iREN || i_done)  state_d = arb;
      DGRANT:  if (!d_req || d_done) state_d = arb;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM drive and completion handshake for the granted requester
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    case (state_q)
      IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            i_done = 1'b1;
            iwait  = 1'b0;
            iload  = (rs == ERROR) ? BAD_LD : ramload;
          end
        end
      end
      DGRANT: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          // A simultaneous read and write request is served as a write
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          if (ram_done) begin
            d_done = 1'b1;
            dwait  = 1'b0;
            dload  = (rs == ERROR) ? BAD_LD : ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    tick();
    tick();
  endtask

  task automatic test_reset();
    nRST = 0; iREN = 1; dREN = 1; dWEN = 1; iaddr = 32'h44; daddr = 32'h88;
    dstore = 32'h1234; ramload = 32'h5555; ramstate = ACCESS;
    tick(); #2;
    n_checks++;
    if ({iwait, dwait, ramREN, ramWEN, mem_err} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 11000", {iwait, dwait, ramREN, ramWEN, mem_err});
    end
    n_checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0", ramaddr, ramstore, iload, dload);
    end
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    tick();
    nRST = 1;
    tick();
  endtask

  task automatic test_single_fetch();
    iREN = 1; iaddr = 32'h0000_0040; ramstate = BUSY; ramload = 32'h0;
    #2;
    n_checks++;
    if ({ramREN, iwait, dwait} !== 3'b011) begin
      n_fail++; $display("FAIL fetch_c0: got %b want 011", {ramREN, iwait, dwait});
    end
    for (int c = 1; c <= 2; c++) begin
      tick(); #2;
      n_checks++;
      if ({ramREN, ramWEN, iwait, dwait, ramaddr} !== {4'b1011, 32'h40}) begin
        n_fail++; $display("FAIL fetch_busy%0d: got %b addr %h want 1011 addr 40", c, {ramREN, ramWEN, iwait, dwait}, ramaddr);
      end
    end
    tick();
    ramstate = ACCESS; ramload = 32'h2008_0005;
    #2;
    n_checks++;
    if ({iwait, dwait, iload, dload} !== {2'b01, 32'h2008_0005, 32'h0}) begin
      n_fail++; $display("FAIL fetch_access: got iw=%b dw=%b iload=%h dload=%h want 0 1 20080005 0", iwait, dwait, iload, dload);
    end
    go_idle();
  endtask

  task automatic test_data_priority();
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100; ramstate = ACCESS; ramload = 32'h11;
    tick(); #2;
    n_checks++;
    if ({ramREN, ramWEN, dwait, iwait, ramaddr, dload} !== {4'b1001, 32'h100, 32'h11}) begin
      n_fail++; $display("FAIL prio_dgrant: got %b addr %h dload %h want 1001 100 11", {ramREN, ramWEN, dwait, iwait}, ramaddr, dload);
    end
    tick();
    dREN = 0;
    #2;
    n_checks++;
    if ({iwait, dwait} !== 2'b11) begin
      n_fail++; $display("FAIL prio_drop: got %b want 11", {iwait, dwait});
    end
    tick(); #2;
    n_checks++;
    if ({ramREN, iwait, dwait, ramaddr, iload} !== {3'b101, 32'h80, 32'h11}) begin
      n_fail++; $display("FAIL prio_fetch: got %b addr %h iload %h want 101 80 11", {ramREN, iwait, dwait}, ramaddr, iload);
    end
    go_idle();
  endtask

  task automatic test_starvation();
    logic [9:0] is_fetch;
    is_fetch = 10'b10000_10000;  // bit c-1 set where cycle c is a fetch
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h300; dstore = 32'h77; ramstate = ACCESS;
    for (int c = 1; c <= 10; c++) begin
      tick(); #2;
      n_checks++;
      if (is_fetch[c-1]) begin
        if ({iwait, dwait, ramREN, ramaddr} !== {3'b011, 32'h44}) begin
          n_fail++; $display("FAIL starve_c%0d: got %b addr %h want fetch 011 44", c, {iwait, dwait, ramREN}, ramaddr);
        end
      end else begin
        if ({iwait, dwait, ramWEN, ramaddr} !== {3'b101, 32'h300}) begin
          n_fail++; $display("FAIL starve_c%0d: got %b addr %h want data 101 300", c, {iwait, dwait, ramWEN}, ramaddr);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_write();
    dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    tick(); #2;
    n_checks++;
    if ({ramWEN, ramREN, dwait, ramaddr, ramstore} !== {3'b101, 32'h200, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL write_drive: got %b addr %h store %h want 101 200 deadbeef", {ramWEN, ramREN, dwait}, ramaddr, ramstore);
    end
    tick();
    ramstate = ACCESS;
    #2;
    n_checks++;
    if ({dwait, iwait, ramWEN} !== 3'b011) begin
      n_fail++; $display("FAIL write_done: got %b want 011", {dwait, iwait, ramWEN});
    end
    go_idle();
  endtask

  task automatic test_error();
    int bad;
    bad = 0;
    iREN = 1; iaddr = 32'h10; ramstate = ERROR;
    tick(); #2;
    n_checks++;
    if ({iwait, dwait, mem_err, iload} !== {3'b010, 32'hBAD1_BAD1}) begin
      n_fail++; $display("FAIL err_cycle: got %b iload %h want 010 bad1bad1", {iwait, dwait, mem_err}, iload);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      ramstate = ACCESS; ramload = 32'h1000 + k;
      #2;
      if ((iwait !== 1'b0) || (iload !== 32'h1000 + k)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL err_good_txns: got %0d bad completions want 0", bad);
    end
    n_checks++;
    if (mem_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", mem_err);
    end
    go_idle();
  endtask

  task automatic test_abort();
    iREN = 1; iaddr = 32'h20; ramstate = BUSY;
    tick(); #2;
    n_checks++;
    if ({ramREN, iwait} !== 2'b11) begin
      n_fail++; $display("FAIL abort_grant: got %b want 11", {ramREN, iwait});
    end
    tick();
    iREN = 0;
    #2;
    n_checks++;
    if (iwait !== 1'b1) begin
      n_fail++; $display("FAIL abort_nopulse: got %b want 1", iwait);
    end
    tick();
    iREN = 1; ramstate = ACCESS;
    #2;
    n_checks++;
    if ({iwait, ramREN, ramaddr} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL abort_idle: got %b addr %h want 10 0", {iwait, ramREN}, ramaddr);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    dWEN = 1; daddr = 32'h400; dstore = 32'h99; ramstate = BUSY;
    tick(); #2;
    n_checks++;
    if ({ramWEN, dwait} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_grant: got %b want 11", {ramWEN, dwait});
    end
    nRST = 0;
    #1;
    n_checks++;
    if ({ramWEN, ramREN, dwait, mem_err, ramaddr} !== {4'b0010, 32'h0}) begin
      n_fail++; $display("FAIL rstmid_async: got %b addr %h want 0010 0", {ramWEN, ramREN, dwait, mem_err}, ramaddr);
    end
    tick();
    nRST = 1;
    ramstate = ACCESS;
    #2;
    n_checks++;
    if ({ramWEN, dwait} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_idle: got %b want 01", {ramWEN, dwait});
    end
    tick(); #2;
    n_checks++;
    if ({ramWEN, dwait, ramaddr} !== {2'b10, 32'h400}) begin
      n_fail++; $display("FAIL rstmid_fresh: got %b addr %h want 10 400", {ramWEN, dwait}, ramaddr);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_starvation();
    test_write();
    test_error();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data (load/store) requester of the pipelined CPU.
- Sits between the caches/datapath and the RAM model.
- Its wait outputs are what the hazard logic and pipeline latches use to stall.
- Data accesses have priority; a starvation counter guarantees instruction-fetch progress.

Parameters:
- WORD_W, 32, width of addresses and data words.
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction fetch is pending before the fetch is forced through (range 1..15).

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request, held until iwait low
- iaddr  input  WORD_W  instruction address
- iwait  output  1  instruction requester must stall
- iload  output  WORD_W  instruction word returned
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  WORD_W  data address
- dstore  input  WORD_W  data to write
- dwait  output  1  data requester must stall
- dload  output  WORD_W  data word returned
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  WORD_W  RAM address
- ramstore  output  WORD_W  RAM write data
- ramload  input  WORD_W  RAM read data
- ramstate  input  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  output  1  sticky error flag

Behaviour:
- FSM states: IDLE, IGRANT, DGRANT, all registered.
- Reset (async, nRST low) state:
  - state=IDLE, starve_cnt=0, mem_err=0.
  - Outputs during/after reset: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
- Arbitration is evaluated in IDLE, and also on the completion cycle of a grant, which allows back-to-back grants with no bubble:
  - Data pending (dREN|dWEN) and no fetch pending -> DGRANT.
  - Fetch pending and no data pending -> IGRANT.
  - Both pending -> IGRANT if starve_cnt==STARVE_LIMIT, else DGRANT.
  - Neither pending -> IDLE.
- Grant latency: a request first seen in IDLE drives the RAM from the next cycle; at least 1 cycle of wait.
- IGRANT drives: ramREN=1, ramWEN=0, ramaddr=iaddr.
- DGRANT drives: ramaddr=daddr, ramstore=dstore.
  - dWEN=1 -> ramWEN=1, ramREN=0.
  - dWEN=1 and dREN=1 together -> treated as a write.
  - Otherwise ramREN=1.
- IDLE drives: ram enables 0, ramaddr=0.
- Completion occurs when ramstate==ACCESS in a grant state, and is combinational in that cycle:
  - The granted requester's wait=0 and its load=ramload.
  - The other requester's wait stays 1.
- ramstate FREE or BUSY: hold the grant and keep the RAM signals stable.
- ramstate==ERROR in a grant state:
  - mem_err set to 1 on the next edge; stays set until reset.
  - The transaction completes with wait=0 and load=32'hBAD1BAD1 so the pipeline does not hang.
- Requester drops its request while granted (IGRANT with iREN=0, or DGRANT with dREN=dWEN=0):
  - No completion is signalled.
  - The FSM re-arbitrates on that edge as if in IDLE.
- starve_cnt updates on the clock edge:
  - Data completion while iREN=1 -> increment, saturating at STARVE_LIMIT.
  - Instruction completion, or iREN=0 -> 0.
- A requester's wait is 1 whenever it is not the granted completing requester.
- The load output of a requester not completing is 0.
- Reset mid-transaction: abort immediately; the RAM enables drop asynchronously.

Decomposition:
- cpu_types_pkg holds:
  - ramstate_t
  - word_t (WORD_W)
  - arb_state_t enum {IDLE, IGRANT, DGRANT}
  - localparam BAD_WORD = 32'hBAD1BAD1
- A single module; no sub-module is natural. The FSM, starvation counter and output mux fit in one file.
- Add a modport-based mem_arbiter_if interface with an arb modport matching the ports above.

Test Plan:
- Single fetch: iREN=1, iaddr=0x0000_0040; ramstate BUSY 2 cycles then ACCESS with ramload=0x2008_0005 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x2008_0005 only on the ACCESS cycle; dwait=1 throughout.
- Data priority: iREN=1, dREN=1 (daddr=0x100) in the same cycle, ACCESS every cycle -> DGRANT first with ramaddr=0x100; fetch is served on the next arbitration.
- Starvation: iREN held high, dWEN asserted continuously for 10 requests, STARVE_LIMIT=4 -> exactly 4 data completions, then one instruction completion, then 4 data completions again; starve_cnt resets to 0 after the fetch.
- Write path: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
- Error: ramstate=ERROR during IGRANT -> iwait=0, iload=0xBAD1BAD1 that cycle; mem_err=1 from the next cycle and still 1 after 20 further good transactions.
- Abort/reset: iREN dropped in cycle 2 of IGRANT -> no iwait=0 pulse, state returns to IDLE; separately, nRST pulled low mid-DGRANT -> ramWEN=0 immediately, and a fresh request after release behaves as from reset.
